// File: rtl/pv_crosslayer_if.sv
// Bus bundle for the PV+ cross-layer engine: tick/drive in, inhibition and status out.
// Optional readback (PV_READBACK_EN) adds rb_sel / rb_state.
interface pv_crosslayer_if #(
  parameter int WIDTH = 18,
  parameter int N_CH  = 3
);
  logic                    clk_en;
  logic [N_CH*WIDTH-1:0]   pyr_in;
  logic [N_CH*WIDTH-1:0]   pv_inhib;
  logic [WIDTH-1:0]        total_inhib;
  logic                    total_valid;
  logic                    busy;
  logic                    overrun;
`ifdef PV_READBACK_EN
  localparam int RBW = (N_CH > 1) ? $clog2(N_CH) : 1;
  logic [RBW-1:0]          rb_sel;
  logic [WIDTH-1:0]        rb_state;

  modport master (output clk_en, pyr_in, rb_sel,
                  input  pv_inhib, total_inhib, total_valid, busy, overrun, rb_state);
  modport slave  (input  clk_en, pyr_in, rb_sel,
                  output pv_inhib, total_inhib, total_valid, busy, overrun, rb_state);
`else
  modport master (output clk_en, pyr_in,
                  input  pv_inhib, total_inhib, total_valid, busy, overrun);
  modport slave  (input  clk_en, pyr_in,
                  output pv_inhib, total_inhib, total_valid, busy, overrun);
`endif
endinterface

// File: rtl/pv_crosslayer_engine.sv
// Channel-serial PV+ interneuron engine. Each clk_en tick snapshots the drive,
// leaks every channel's integrator one per clk, then emits the saturated
// weighted total. Optional state readback is enabled with PV_READBACK_EN.
module pv_crosslayer_engine #(
  parameter int              WIDTH     = 18,
  parameter int              FRAC      = 14,
  parameter int              N_CH      = 3,
  parameter int              TAU_SHIFT = 4,
  parameter logic [3*N_CH-1:0] WSHIFT  = 9'b010_001_000
) (
  input  logic clk,
  input  logic rst,
  pv_crosslayer_if.slave bus
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW  = WIDTH + $clog2(N_CH) + 1;

  localparam logic signed [WIDTH-1:0] S_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN_IN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH+1:0] SAT_HI   = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] SAT_LO   = -SAT_HI;
  localparam logic [AW-1:0]           ACC_MAX  = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  // Parameter sanity, caught at elaboration.
  if (N_CH < 1 || N_CH > 15) begin : g_bad_nch
    $error("N_CH must be 1..15");
  end
  if (FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must be below WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} fsm_t;

  fsm_t                        fsm_q, fsm_d;
  logic [CHW-1:0]              ch_q, ch_d;
  logic [AW-1:0]               acc_q, acc_d;
  logic [N_CH-1:0][WIDTH-1:0]  shadow_q, shadow_d;
  logic [N_CH-1:0][WIDTH-1:0]  state_q, state_d;
  logic [N_CH-1:0][WIDTH-1:0]  pv_q, pv_d;
  logic [WIDTH-1:0]            total_q, total_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;

  logic signed [WIDTH-1:0]     cur_in, drv, cur_st, new_st;
  logic signed [WIDTH:0]       diff, step;
  logic signed [WIDTH+1:0]     sum;
  logic [WIDTH-1:0]            pos, contrib;
  logic [2:0]                  wsh;

  // Per-channel integrator datapath for the channel selected by ch_q.
  always_comb begin
    cur_in = $signed(shadow_q[ch_q]);
    if (cur_in == S_MIN_IN)  drv = S_MAX;
    else if (cur_in < 0)     drv = -cur_in;
    else                     drv = cur_in;
    cur_st = $signed(state_q[ch_q]);
    diff   = {drv[WIDTH-1], drv} - {cur_st[WIDTH-1], cur_st};
    step   = diff >>> TAU_SHIFT;
    sum    = {cur_st[WIDTH-1], cur_st[WIDTH-1], cur_st} + {step[WIDTH], step};
    if (sum > SAT_HI)        new_st = S_MAX;
    else if (sum < SAT_LO)   new_st = -S_MAX;
    else                     new_st = sum[WIDTH-1:0];
    pos     = new_st[WIDTH-1] ? '0 : new_st;
    wsh     = WSHIFT[ch_q*3 +: 3];
    contrib = pos >> wsh;
  end

  // Sweep FSM next-state and all registered outputs.
  always_comb begin
    fsm_d     = fsm_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    shadow_d  = shadow_q;
    state_d   = state_q;
    pv_d      = pv_q;
    total_d   = total_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    case (fsm_q)
      IDLE: begin
        if (bus.clk_en) begin
          shadow_d = bus.pyr_in;
          acc_d    = '0;
          ch_d     = '0;
          busy_d   = 1'b1;
          fsm_d    = SWEEP;
        end
      end
      SWEEP: begin
        if (bus.clk_en) overrun_d = 1'b1;
        state_d[ch_q] = new_st;
        pv_d[ch_q]    = pos;
        acc_d         = acc_q + AW'(contrib);
        if (ch_q == CHW'(N_CH-1)) fsm_d = DONE;
        else                      ch_d  = ch_q + 1'b1;
      end
      DONE: begin
        if (bus.clk_en) overrun_d = 1'b1;
        total_d = (acc_q > ACC_MAX) ? S_MAX : acc_q[WIDTH-1:0];
        valid_d = 1'b1;
        busy_d  = 1'b0;
        fsm_d   = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers; synchronous reset aborts any sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      ch_q      <= '0;
      acc_q     <= '0;
      shadow_q  <= '0;
      state_q   <= '0;
      pv_q      <= '0;
      total_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      shadow_q  <= shadow_d;
      state_q   <= state_d;
      pv_q      <= pv_d;
      total_q   <= total_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.pv_inhib    = pv_q;
  assign bus.total_inhib = total_q;
  assign bus.total_valid = valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;

`ifdef PV_READBACK_EN
  logic [WIDTH-1:0] rb_state_q, rb_state_d;

  // Readback samples the registered state, so a concurrent write shows the old value.
  always_comb begin
    rb_state_d = '0;
    if (32'(bus.rb_sel) < N_CH) rb_state_d = state_q[bus.rb_sel];
  end

  // Readback register.
  always_ff @(posedge clk) begin
    if (rst) rb_state_q <= '0;
    else     rb_state_q <= rb_state_d;
  end

  assign bus.rb_state = rb_state_q;
`endif

endmodule
